// File: rtl/wb_dest_tracker_if.sv
// Purpose: groups ID issue fields, pipeline control and stage destination outputs of wb_dest_tracker.
// Latency: n/a (wiring only); stall_cnt exists only when LOAD_USE_STALL_CNT_EN is defined.
// Backpressure: freeze holds all stages; load_use_stall tells ID to hold its instruction.
interface wb_dest_tracker_if #(
    parameter int REG_W = 5
`ifdef LOAD_USE_STALL_CNT_EN
    , parameter int CNT_W = 16
`endif
) ();
    logic             id_valid;
    logic             id_wen;
    logic [REG_W-1:0] id_wnum;
    logic             id_is_load;
    logic [REG_W-1:0] id_rs;
    logic [REG_W-1:0] id_rt;
    logic             id_rs_used;
    logic             id_rt_used;
    logic             freeze;
    logic             flush;
    logic             exe_wen;
    logic [REG_W-1:0] exe_wnum;
    logic             mem_wen;
    logic [REG_W-1:0] mem_wnum;
    logic             wb_wen;
    logic [REG_W-1:0] wb_wnum;
    logic             exe_is_load;
    logic             load_use_stall;
`ifdef LOAD_USE_STALL_CNT_EN
    logic [CNT_W-1:0] stall_cnt;
`endif

    // Issue side: drives ID fields and pipeline control, consumes stage destinations.
    modport master (
        output id_valid, id_wen, id_wnum, id_is_load,
        output id_rs, id_rt, id_rs_used, id_rt_used,
        output freeze, flush,
        input  exe_wen, exe_wnum, mem_wen, mem_wnum, wb_wen, wb_wnum,
        input  exe_is_load, load_use_stall
`ifdef LOAD_USE_STALL_CNT_EN
        , input stall_cnt
`endif
    );

    // Tracker side.
    modport slave (
        input  id_valid, id_wen, id_wnum, id_is_load,
        input  id_rs, id_rt, id_rs_used, id_rt_used,
        input  freeze, flush,
        output exe_wen, exe_wnum, mem_wen, mem_wnum, wb_wen, wb_wnum,
        output exe_is_load, load_use_stall
`ifdef LOAD_USE_STALL_CNT_EN
        , output stall_cnt
`endif
    );
endinterface

// File: rtl/wb_dest_tracker.sv
// Purpose: carries issued destinations through EXE/MEM/WB for forwarding and flags load-use hazards.
// Latency: exe_* 1 edge after issue, mem_* 2, wb_* 3; load_use_stall is combinational.
// Backpressure: freeze holds all stages (flush still clears EXE); optional LOAD_USE_STALL_CNT_EN adds stall_cnt.
module wb_dest_tracker #(
    parameter int REG_W = 5
`ifdef LOAD_USE_STALL_CNT_EN
    , parameter int CNT_W = 16
`endif
) (
    input  logic              clk,
    input  logic              resetn,
    wb_dest_tracker_if.slave  bus
);
    logic             exe_wen_q;
    logic [REG_W-1:0] exe_wnum_q;
    logic             exe_ld_q;
    logic             mem_wen_q;
    logic [REG_W-1:0] mem_wnum_q;
    logic             wb_wen_q;
    logic [REG_W-1:0] wb_wnum_q;
    logic             rs_hit;
    logic             rt_hit;
    logic             stall;
    logic             issue_ok;
    logic             id_wen_eff;

    // Hazard detect: a load in EXE whose result a valid ID instruction reads.
    // $0 sources cannot match because a $0 destination never has exe_wen set.
    always_comb begin
        rs_hit     = bus.id_rs_used && (bus.id_rs == exe_wnum_q);
        rt_hit     = bus.id_rt_used && (bus.id_rt == exe_wnum_q);
        stall      = bus.id_valid && exe_ld_q && exe_wen_q && (rs_hit || rt_hit);
        issue_ok   = bus.id_valid && !stall && !bus.flush;
        id_wen_eff = bus.id_wen && (bus.id_wnum != '0);
    end

    // EXE stage: flush wins even under freeze; otherwise take ID or insert a bubble.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            exe_wen_q  <= 1'b0;
            exe_wnum_q <= '0;
            exe_ld_q   <= 1'b0;
        end else if (bus.flush) begin
            exe_wen_q  <= 1'b0;
            exe_wnum_q <= '0;
            exe_ld_q   <= 1'b0;
        end else if (!bus.freeze) begin
            if (issue_ok) begin
                exe_wen_q  <= id_wen_eff;
                exe_wnum_q <= bus.id_wnum;
                exe_ld_q   <= bus.id_is_load;
            end else begin
                exe_wen_q  <= 1'b0;
                exe_wnum_q <= '0;
                exe_ld_q   <= 1'b0;
            end
        end
    end

    // MEM and WB stages: plain shift, held while frozen.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            mem_wen_q  <= 1'b0;
            mem_wnum_q <= '0;
            wb_wen_q   <= 1'b0;
            wb_wnum_q  <= '0;
        end else if (!bus.freeze) begin
            mem_wen_q  <= exe_wen_q;
            mem_wnum_q <= exe_wnum_q;
            wb_wen_q   <= mem_wen_q;
            wb_wnum_q  <= mem_wnum_q;
        end
    end

`ifdef LOAD_USE_STALL_CNT_EN
    logic [CNT_W-1:0] stall_cnt_q;

    // Saturating count of stall cycles that actually took effect (not frozen).
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            stall_cnt_q <= '0;
        end else if (stall && !bus.freeze && (stall_cnt_q != '1)) begin
            stall_cnt_q <= stall_cnt_q + 1'b1;
        end
    end

    assign bus.stall_cnt = stall_cnt_q;
`endif

    assign bus.exe_wen        = exe_wen_q;
    assign bus.exe_wnum       = exe_wnum_q;
    assign bus.exe_is_load    = exe_ld_q;
    assign bus.mem_wen        = mem_wen_q;
    assign bus.mem_wnum       = mem_wnum_q;
    assign bus.wb_wen         = wb_wen_q;
    assign bus.wb_wnum        = wb_wnum_q;
    assign bus.load_use_stall = stall;
endmodule

// File: tb/tb_wb_dest_tracker.sv
// Purpose: self-checking bench for wb_dest_tracker, directed scenarios then random issue traffic.
// Latency: checks registered outputs 1 time unit after each rising edge, stall before the edge.
// Backpressure: random freeze/flush mixed into the random phase.
module tb_wb_dest_tracker;
    logic clk = 1'b0;
    logic resetn;
    always #5 clk = ~clk;

    wb_dest_tracker_if bus ();

    wb_dest_tracker dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    int total = 0;
    int bad   = 0;

    // Reference model: one record per in-flight instruction slot, oldest last.
    typedef struct {
        bit       wen;
        bit [4:0] wnum;
        bit       ld;
    } dest_t;

    dest_t       slot_exe, slot_mem, slot_wb;
    int unsigned m_cnt;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        slot_exe = '{0, 0, 0};
        slot_mem = '{0, 0, 0};
        slot_wb  = '{0, 0, 0};
        m_cnt    = 0;
    endtask

    // The ID instruction must wait if it reads what a load still in EXE will produce.
    function automatic bit model_stall();
        bit needs;
        if (!bus.id_valid || !slot_exe.ld || !slot_exe.wen) return 1'b0;
        needs = (bus.id_rs_used && bus.id_rs == slot_exe.wnum) ||
                (bus.id_rt_used && bus.id_rt == slot_exe.wnum);
        return needs;
    endfunction

    task automatic drive(input bit v, input bit w, input bit [4:0] wn, input bit ld,
                         input bit [4:0] rs, input bit [4:0] rt, input bit rsu, input bit rtu,
                         input bit frz, input bit fl);
        bus.id_valid   = v;
        bus.id_wen     = w;
        bus.id_wnum    = wn;
        bus.id_is_load = ld;
        bus.id_rs      = rs;
        bus.id_rt      = rt;
        bus.id_rs_used = rsu;
        bus.id_rt_used = rtu;
        bus.freeze     = frz;
        bus.flush      = fl;
    endtask

    task automatic idle(input bit frz, input bit fl);
        drive(0, 0, 0, 0, 0, 0, 0, 0, frz, fl);
    endtask

    task automatic check_outputs();
        check_eq("exe_wen",     bus.exe_wen,     slot_exe.wen);
        check_eq("exe_wnum",    bus.exe_wnum,    slot_exe.wnum);
        check_eq("exe_is_load", bus.exe_is_load, slot_exe.ld);
        check_eq("mem_wen",     bus.mem_wen,     slot_mem.wen);
        check_eq("mem_wnum",    bus.mem_wnum,    slot_mem.wnum);
        check_eq("wb_wen",      bus.wb_wen,      slot_wb.wen);
        check_eq("wb_wnum",     bus.wb_wnum,     slot_wb.wnum);
`ifdef LOAD_USE_STALL_CNT_EN
        check_eq("stall_cnt",   bus.stall_cnt,   m_cnt);
`endif
    endtask

    // One clock: check the stall, advance the model as the pipeline rules say, check stages.
    task automatic tick();
        bit s;
        #1;
        s = model_stall();
        check_eq("stall", bus.load_use_stall, s);
        @(posedge clk);
        if (!bus.freeze) begin
            slot_wb  = slot_mem;
            slot_mem = slot_exe;
            if (bus.id_valid && !s && !bus.flush)
                slot_exe = '{bus.id_wen && (bus.id_wnum != 0), bus.id_wnum, bus.id_is_load};
            else
                slot_exe = '{0, 0, 0};
            if (s && m_cnt != 32'hFFFF) m_cnt++;
        end else if (bus.flush) begin
            slot_exe = '{0, 0, 0};
        end
        #1;
        check_outputs();
    endtask

    task automatic check_all_zero(input string tag);
        check_eq({tag, "_exe_wen"},  bus.exe_wen,     0);
        check_eq({tag, "_exe_wnum"}, bus.exe_wnum,    0);
        check_eq({tag, "_exe_ld"},   bus.exe_is_load, 0);
        check_eq({tag, "_mem_wen"},  bus.mem_wen,     0);
        check_eq({tag, "_mem_wnum"}, bus.mem_wnum,    0);
        check_eq({tag, "_wb_wen"},   bus.wb_wen,      0);
        check_eq({tag, "_wb_wnum"},  bus.wb_wnum,     0);
    endtask

    initial begin
        resetn = 1'b0;
        idle(0, 0);
        model_reset();
        #1;
        check_all_zero("rst");
        repeat (2) @(posedge clk);
        #1;
        resetn = 1'b1;

        // ALU op to $8 walks EXE -> MEM -> WB.
        drive(1, 1, 8, 0, 0, 0, 0, 0, 0, 0);
        tick();
        check_eq("alu_exe_wen", bus.exe_wen, 1);
        check_eq("alu_exe_wnum", bus.exe_wnum, 8);
        idle(0, 0);
        tick();
        check_eq("alu_mem_wnum", bus.mem_wnum, 8);
        check_eq("alu_mem_wen", bus.mem_wen, 1);
        check_eq("alu_exe_idle", bus.exe_wen, 0);
        tick();
        check_eq("alu_wb_wnum", bus.wb_wnum, 8);
        check_eq("alu_wb_wen", bus.wb_wen, 1);
        tick();
        check_eq("alu_wb_drain", bus.wb_wen, 0);

        // Write to $0 is never enabled.
        drive(1, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        tick();
        check_eq("z_exe_wen", bus.exe_wen, 0);
        idle(0, 0);
        tick();
        check_eq("z_mem_wen", bus.mem_wen, 0);
        tick();
        check_eq("z_wb_wen", bus.wb_wen, 0);

        // Load $9 then a dependent reader: exactly one stall cycle.
        drive(1, 1, 9, 1, 0, 0, 0, 0, 0, 0);
        tick();
        drive(1, 1, 10, 0, 9, 0, 1, 0, 0, 0);
        #1;
        check_eq("lu_stall_on", bus.load_use_stall, 1);
        tick();
        check_eq("lu_bubble", bus.exe_wen, 0);
        check_eq("lu_ld_mem", bus.mem_wnum, 9);
        #1;
        check_eq("lu_stall_off", bus.load_use_stall, 0);
        tick();
        check_eq("lu_issue_wnum", bus.exe_wnum, 10);
        check_eq("lu_issue_wen", bus.exe_wen, 1);
`ifdef LOAD_USE_STALL_CNT_EN
        check_eq("lu_cnt", bus.stall_cnt, 1);
`endif

        // Load $9 then a reader that does not use rs: no stall.
        drive(1, 1, 9, 1, 0, 0, 0, 0, 0, 0);
        tick();
        drive(1, 1, 10, 0, 9, 0, 0, 0, 0, 0);
        #1;
        check_eq("nouse_stall", bus.load_use_stall, 0);
        tick();
        check_eq("nouse_exe", bus.exe_wnum, 10);

        // $3, $4 then freeze for three cycles.
        drive(1, 1, 3, 0, 0, 0, 0, 0, 0, 0);
        tick();
        drive(1, 1, 4, 0, 0, 0, 0, 0, 0, 0);
        tick();
        for (int i = 0; i < 3; i++) begin
            idle(1, 0);
            tick();
            check_eq("frz_exe", bus.exe_wnum, 4);
            check_eq("frz_mem", bus.mem_wnum, 3);
        end
        idle(0, 0);
        tick();
        check_eq("frz_rel_mem", bus.mem_wnum, 4);
        check_eq("frz_rel_wb", bus.wb_wnum, 3);

        // Flush kills the issue of $5 while MEM/WB shift.
        drive(1, 1, 5, 0, 0, 0, 0, 0, 0, 1);
        tick();
        check_eq("fl_exe_wen", bus.exe_wen, 0);
        check_eq("fl_wb_shift", bus.wb_wnum, 4);

        // Freeze with flush: EXE cleared, MEM/WB held.
        drive(1, 1, 6, 0, 0, 0, 0, 0, 0, 0);
        tick();
        drive(1, 1, 7, 0, 0, 0, 0, 0, 0, 0);
        tick();
        idle(1, 1);
        tick();
        check_eq("ff_exe_wen", bus.exe_wen, 0);
        check_eq("ff_mem_wnum", bus.mem_wnum, 6);
        check_eq("ff_wb_wen", bus.wb_wen, 0);

        // Async reset mid-stream clears everything before the next edge.
        drive(1, 1, 12, 0, 0, 0, 0, 0, 0, 0);
        tick();
        drive(1, 1, 13, 1, 0, 0, 0, 0, 0, 0);
        tick();
        #2;
        resetn = 1'b0;
        #1;
        check_all_zero("arst");
`ifdef LOAD_USE_STALL_CNT_EN
        check_eq("arst_cnt", bus.stall_cnt, 0);
`endif
        model_reset();
        @(posedge clk);
        #1;
        resetn = 1'b1;
        drive(1, 1, 13, 1, 13, 0, 1, 0, 0, 0);
        #1;
        check_eq("cold_nostall", bus.load_use_stall, 0);
        tick();
        check_eq("cold_exe", bus.exe_wnum, 13);

        // Random traffic with small register range to provoke hazards.
        for (int i = 0; i < 1500; i++) begin
            drive($urandom_range(0, 3) != 0, $urandom_range(0, 1), 5'($urandom_range(0, 7)),
                  $urandom_range(0, 1), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                  $urandom_range(0, 1), $urandom_range(0, 1),
                  $urandom_range(0, 7) == 0, $urandom_range(0, 15) == 0);
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/wb_dest_tracker.md
Name: wb_dest_tracker

Overview:
- Producer side of the forwarding interface: generates the exe/mem/wb write-enable and write-number signals that the forwarding-select detect unit consumes.
- Carries each issued instruction's destination info through the EXE, MEM and WB stage registers.
- Honours pipeline freeze and flush.
- Raises a load-use stall when forwarding cannot cover a dependency.
- Sits between ID issue logic and the forwarding-select detect unit.

Parameters:
- REG_W, 5, register-number width.
- CNT_W, 16, stall-counter width (used only with the optional feature).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- resetn  in  1  reset, asynchronous, active-low.
- id_valid  in  1  the ID stage holds a valid instruction this cycle.
- id_wen  in  1  the ID instruction writes the GPR file.
- id_wnum  in  REG_W  destination register of the ID instruction.
- id_is_load  in  1  the ID instruction is a load.
- id_rs  in  REG_W  source register rs of the ID instruction.
- id_rt  in  REG_W  source register rt of the ID instruction.
- id_rs_used  in  1  the ID instruction actually reads rs.
- id_rt_used  in  1  the ID instruction actually reads rt.
- freeze  in  1  memory-side stall; all stage registers hold.
- flush  in  1  exception/redirect; kill the instruction entering EXE.
- exe_wen  out  1  EXE-stage write enable.
- exe_wnum  out  REG_W  EXE-stage destination register.
- mem_wen  out  1  MEM-stage write enable.
- mem_wnum  out  REG_W  MEM-stage destination register.
- wb_wen  out  1  WB-stage write enable.
- wb_wnum  out  REG_W  WB-stage destination register.
- exe_is_load  out  1  the EXE instruction is a load.
- load_use_stall  out  1  ID must hold and a bubble enters EXE.

Behaviour:
- Reset (asynchronous, resetn=0): all *_wen=0, all *_wnum=0, exe_is_load=0. Outputs take these values immediately, independent of clk.
- Stage registers: EXE {wen, wnum, is_load}, MEM {wen, wnum}, WB {wen, wnum}. Outputs are driven directly from these registers; no combinational path from inputs to the *_wen/*_wnum outputs.
- Zero-register rule: a stage wen is loaded as id_wen & (id_wnum!=0). A write to $0 never appears enabled at any stage.
- load_use_stall (combinational) = exe_is_load & exe_wen & ((id_rs_used & id_rs==exe_wnum) | (id_rt_used & id_rt==exe_wnum)) & id_valid.
  - Sources equal to 0 can never match, because of the zero-register rule.
- Advance rule, each rising edge with freeze=0:
  - WB <= MEM.
  - MEM <= EXE.
  - EXE <= ID fields if id_valid & ~load_use_stall & ~flush; otherwise EXE <= bubble (wen=0, wnum=0, is_load=0).
- freeze=1 and flush=0: every stage register holds. load_use_stall is still computed from the held EXE contents.
- freeze=1 and flush=1: MEM and WB hold; EXE is cleared to a bubble. Flush takes priority on EXE only.
- Latency: an instruction issued at edge N appears on exe_* after edge N, mem_* after N+1, wb_* after N+2, provided there is no freeze.
- A load in EXE with a dependent instruction in ID produces exactly one stall cycle. The load then moves to MEM, where its data can be forwarded.
- resetn deasserted mid-operation discards all in-flight destinations. The first valid issue after reset behaves as on a cold pipeline.

Optional Feature:
- Macro: LOAD_USE_STALL_CNT_EN.
- When defined:
  - Adds output stall_cnt, CNT_W bits wide, reset to 0.
  - stall_cnt increments on each rising edge where load_use_stall=1 and freeze=0.
  - stall_cnt saturates at all-ones; it does not wrap.
- When undefined:
  - The port and the counter are absent.
  - All other behaviour is identical.

Test Plan:
- Cold reset, then an ALU op with id_wnum=8, id_wen=1 -> exe_wen=1/exe_wnum=8 after 1 edge, mem_* after 2 edges, wb_* after 3 edges; then all wen=0 with idle ID.
- Write to $0 (id_wnum=0, id_wen=1) -> exe_wen, mem_wen and wb_wen stay 0 throughout.
- Load to $9 followed by an instruction with id_rs=9, id_rs_used=1 -> load_use_stall=1 for exactly one cycle, EXE bubble (exe_wen=0) for that cycle, then the consumer issues. If LOAD_USE_STALL_CNT_EN is defined, stall_cnt=1.
- Load to $9 followed by a consumer with id_rs=9, id_rs_used=0 -> no stall.
- Issue $3 then $4, then freeze=1 for 3 cycles -> exe/mem contents hold (exe_wnum=4, mem_wnum=3) across the freeze; the pipeline resumes on release.
- flush=1 with a valid issue of $5 -> exe_wen=0 next cycle while the MEM/WB shift continues. freeze=1 and flush=1 together -> EXE cleared, MEM/WB held.
- resetn pulled low mid-stream -> all outputs 0 asynchronously, before the next edge.
